// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and load/store.
// Each access runs IDLE -> BUSY (LATENCY cycles) -> DONE; ties alternate between the ports.
module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall_F,
    output logic        stall_M,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] n_fetch,
    output logic [31:0] n_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state;
    logic       owner_d;   // 1 = data port owns the access in flight
    logic       last_d;    // 1 = data port received the most recent grant
    logic [3:0] cnt;
    logic       grant_d;

    // On a tie the port that did not win last time is served.
    assign grant_d = d_req & (~if_req | ~last_d);

    assign stall_F = if_req & ~if_ack;
    assign stall_M = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            n_fetch   <= '0;
            n_data    <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_d   <= grant_d;
                        last_d    <= grant_d;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        cnt       <= CNT_INIT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Last BUSY cycle: memory data is valid now, complete the access.
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                        if (owner_d) begin
                            d_ack  <= 1'b1;
                            n_data <= n_data + 32'd1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            n_fetch  <= n_fetch + 32'd1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table on a LATENCY=2 instance,
// plus hand sequences for reset abort and LATENCY=1 contention.
module tb_mem_arbiter;

    localparam logic [31:0] IA = 32'h0040_0000, DA = 32'h1001_0000, SA = 32'h1001_0004;
    localparam logic [31:0] IR = 32'h2002_0004, DR = 32'h1111_2222, BE = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // ---------------- instance 1: LATENCY = 2 ----------------
    logic        rst, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata, n_fetch, n_data;
    logic        if_ack, d_ack, stall_F, stall_M, mem_en, mem_we;

    mem_arbiter #(.LATENCY(2)) dut1 (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .stall_F(stall_F), .stall_M(stall_M),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .n_fetch(n_fetch), .n_data(n_data)
    );

    // Memory model: 16 hashed words, unwritten words return preloaded contents.
    logic [31:0] mem [16];
    logic [15:0] wr;

    function automatic logic [3:0] idx(input logic [31:0] a);
        return {a[28], a[22], a[3:2]};
    endfunction

    function automatic logic [31:0] preload(input logic [31:0] a);
        if (a == IA) return IR;
        if (a == DA) return DR;
        return 32'h0;
    endfunction

    assign mem_rdata = wr[idx(mem_addr)] ? mem[idx(mem_addr)] : preload(mem_addr);

    always @(posedge clk) begin
        if (rst) wr <= '0;
        else if (mem_en && mem_we) begin
            mem[idx(mem_addr)] <= mem_wdata;
            wr[idx(mem_addr)]  <= 1'b1;
        end
    end

    // ---------------- instance 2: LATENCY = 1 ----------------
    logic        rst2, if_req2, d_req2;
    logic [31:0] if_addr2, d_addr2;
    logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2, n_fetch2, n_data2;
    logic        if_ack2, d_ack2, stall_F2, stall_M2, mem_en2, mem_we2;

    assign mem_rdata2 = ~mem_addr2;

    mem_arbiter #(.LATENCY(1)) dut2 (
        .clk(clk), .reset(rst2),
        .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ack(if_ack2),
        .d_req(d_req2), .d_we(1'b0), .d_addr(d_addr2), .d_wdata(32'h0),
        .d_rdata(d_rdata2), .d_ack(d_ack2),
        .stall_F(stall_F2), .stall_M(stall_M2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .n_fetch(n_fetch2), .n_data(n_data2)
    );

    typedef struct {
        logic        rst, ireq;
        logic [31:0] iaddr;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata;
        logic        en, we;
        logic [31:0] addr, wdata;
        logic        iack;
        logic [31:0] irdata;
        logic        dack;
        logic [31:0] drdata;
        logic        sf, sm;
        logic [31:0] nf, nd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic en, input logic we,
        input logic [31:0] ad, input logic [31:0] wd, input logic ik, input logic [31:0] ird,
        input logic dk, input logic [31:0] drd, input logic sf, input logic sm,
        input logic [31:0] nf, input logic [31:0] nd);
        vec_t v;
        v.rst = r;  v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da;
        v.dwdata = dwd; v.en = en; v.we = we; v.addr = ad; v.wdata = wd; v.iack = ik;
        v.irdata = ird; v.dack = dk; v.drdata = drd; v.sf = sf; v.sm = sm; v.nf = nf; v.nd = nd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[25];
    vec_t v;
    bit   ok;
    int   ack_cyc[$];
    bit   ack_is_d[$];
    bit   stray;

    initial begin
        // cycle table: rst ireq iaddr dreq dwe daddr dwdata | en we addr wdata iack irdata dack drdata sF sM nf nd
        vecs[0]  = mk(1,1,IA,1,0,DA,0,  0,0,0,0,   0,0,  0,0,  1,1, 0,0);
        vecs[1]  = mk(1,1,IA,1,0,DA,0,  0,0,0,0,   0,0,  0,0,  1,1, 0,0);
        vecs[2]  = mk(0,1,IA,1,0,DA,0,  0,0,0,0,   0,0,  0,0,  1,1, 0,0);
        vecs[3]  = mk(0,1,IA,1,0,DA,0,  1,0,DA,0,  0,0,  0,0,  1,1, 0,0);
        vecs[4]  = mk(0,1,IA,1,0,DA,0,  1,0,DA,0,  0,0,  0,0,  1,1, 0,0);
        vecs[5]  = mk(0,1,IA,1,0,DA,0,  0,0,0,0,   0,0,  1,DR, 1,0, 0,1);
        vecs[6]  = mk(0,1,IA,0,0,0,0,   0,0,0,0,   0,0,  0,DR, 1,0, 0,1);
        vecs[7]  = mk(0,1,IA,0,0,0,0,   1,0,IA,0,  0,0,  0,DR, 1,0, 0,1);
        vecs[8]  = mk(0,1,IA,0,0,0,0,   1,0,IA,0,  0,0,  0,DR, 1,0, 0,1);
        vecs[9]  = mk(0,1,IA,0,0,0,0,   0,0,0,0,   1,IR, 0,DR, 0,0, 1,1);
        vecs[10] = mk(0,0,0,0,0,0,0,    0,0,0,0,   0,IR, 0,DR, 0,0, 1,1);
        vecs[11] = mk(0,1,IA,0,0,0,0,   0,0,0,0,   0,IR, 0,DR, 1,0, 1,1);
        vecs[12] = mk(0,1,IA,0,0,0,0,   1,0,IA,0,  0,IR, 0,DR, 1,0, 1,1);
        vecs[13] = mk(0,1,IA,0,0,0,0,   1,0,IA,0,  0,IR, 0,DR, 1,0, 1,1);
        vecs[14] = mk(0,1,IA,0,0,0,0,   0,0,0,0,   1,IR, 0,DR, 0,0, 2,1);
        vecs[15] = mk(0,0,0,0,0,0,0,    0,0,0,0,   0,IR, 0,DR, 0,0, 2,1);
        vecs[16] = mk(0,0,0,1,1,SA,BE,  0,0,0,0,   0,IR, 0,DR, 0,1, 2,1);
        vecs[17] = mk(0,0,0,1,1,SA,BE,  1,1,SA,BE, 0,IR, 0,DR, 0,1, 2,1);
        vecs[18] = mk(0,0,0,1,1,SA,BE,  1,1,SA,BE, 0,IR, 0,DR, 0,1, 2,1);
        vecs[19] = mk(0,0,0,1,1,SA,BE,  0,0,0,0,   0,IR, 1,DR, 0,0, 2,2);
        vecs[20] = mk(0,0,0,1,0,SA,0,   0,0,0,0,   0,IR, 0,DR, 0,1, 2,2);
        vecs[21] = mk(0,0,0,1,0,SA,0,   1,0,SA,0,  0,IR, 0,DR, 0,1, 2,2);
        vecs[22] = mk(0,0,0,1,0,SA,0,   1,0,SA,0,  0,IR, 0,DR, 0,1, 2,2);
        vecs[23] = mk(0,0,0,1,0,SA,0,   0,0,0,0,   0,IR, 1,BE, 0,0, 2,3);
        vecs[24] = mk(0,0,0,0,0,0,0,    0,0,0,0,   0,IR, 0,BE, 0,0, 2,3);

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        rst2 = 1'b1; if_req2 = 1'b0; if_addr2 = '0; d_req2 = 1'b0; d_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            v = vecs[i];
            rst = v.rst; if_req = v.ireq; if_addr = v.iaddr;
            d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
            @(negedge clk);
            ok = (mem_en === v.en) && (if_ack === v.iack) && (if_rdata === v.irdata) &&
                 (d_ack === v.dack) && (d_rdata === v.drdata) && (stall_F === v.sf) &&
                 (stall_M === v.sm) && (n_fetch === v.nf) && (n_data === v.nd);
            if (v.en) ok = ok && (mem_we === v.we) && (mem_addr === v.addr);
            if (v.en && v.we) ok = ok && (mem_wdata === v.wdata);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL vec%0d: got en=%b we=%b addr=%h wd=%h iack=%b ird=%h dack=%b drd=%h sF=%b sM=%b nf=%0d nd=%0d; expected en=%b we=%b addr=%h wd=%h iack=%b ird=%h dack=%b drd=%h sF=%b sM=%b nf=%0d nd=%0d",
                         i, mem_en, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, d_ack, d_rdata,
                         stall_F, stall_M, n_fetch, n_data, v.en, v.we, v.addr, v.wdata, v.iack,
                         v.irdata, v.dack, v.drdata, v.sf, v.sm, v.nf, v.nd);
            end
            @(posedge clk); #1;
        end

        // Reset in the middle of a fetch: access abandoned, no ack, counters clear.
        if_req = 1'b1; if_addr = IA;
        @(posedge clk); #1;
        @(negedge clk); chk("abort_busy_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk); chk("abort_en_off", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_ack || mem_en) stray = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_ack", 32'(stray), 32'd0);
        chk("abort_n_fetch", n_fetch, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);

        // Sustained contention on the LATENCY=1 instance.
        rst2 = 1'b0; if_req2 = 1'b1; d_req2 = 1'b1;
        if_addr2 = 32'h0040_0100; d_addr2 = 32'h1001_0100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_ack2)  begin ack_cyc.push_back(c); ack_is_d.push_back(1'b1); end
            if (if_ack2) begin ack_cyc.push_back(c); ack_is_d.push_back(1'b0); end
            @(posedge clk); #1;
        end
        chk("cont_ack_count", ack_cyc.size(), 32'd4);
        for (int k = 0; k < ack_cyc.size() && k < 4; k++) begin
            chk($sformatf("cont_ack%0d_cycle", k), ack_cyc[k], 32'(2 + 3 * k));
            chk($sformatf("cont_ack%0d_is_d", k), 32'(ack_is_d[k]), 32'((k % 2) == 0));
        end
        chk("cont_d_rdata", d_rdata2, ~32'h1001_0100);

        // Input changes while BUSY must not disturb the latched access.
        d_req2 = 1'b0; if_addr2 = 32'h0040_0200;
        @(negedge clk); chk("latch_idle_en", 32'(mem_en2), 32'd0);
        @(posedge clk); #1;
        if_addr2 = 32'h0040_0300; if_req2 = 1'b0;
        @(negedge clk);
        chk("latch_busy_en", 32'(mem_en2), 32'd1);
        chk("latch_busy_addr", mem_addr2, 32'h0040_0200);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latch_ack", 32'(if_ack2), 32'd1);
        chk("latch_rdata", if_rdata2, ~32'h0040_0200);
        chk("latch_n_fetch", n_fetch2, 32'd3);
        chk("latch_n_data", n_data2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store). It sequences each access through a fixed-latency memory, returns read data with a one-cycle acknowledge, and drives the stall signals that freeze the pipeline while a requester waits. It replaces the separate instruction and data memories in the pipelined CPU and keeps per-port access counts for the statistics block.

## Interface
- LATENCY, 2, memory access time in cycles (legal 1..15; 4-bit counter)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word, valid with if_ack, held until next fetch completes
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid with d_ack, held until next load completes
- d_ack  out  1  one-cycle completion pulse for data
- stall_F  out  1  if_req & ~if_ack (combinational)
- stall_M  out  1  d_req & ~d_ack (combinational)
- mem_en  out  1  access in progress
- mem_we  out  1  write strobe, valid while mem_en
- mem_addr  out  32  address, stable while mem_en
- mem_wdata  out  32  write data, stable while mem_en
- mem_rdata  in  32  memory read data, valid on the last BUSY cycle
- n_fetch  out  32  completed fetches, wraps 0xFFFFFFFF -> 0
- n_data  out  32  completed data accesses, wraps likewise

## Operation
- States: IDLE, BUSY, DONE. Registers: owner (I/D), last_grant (I/D), cnt[3:0].
- IDLE: if exactly one req high, grant it. If both high, grant the port opposite last_grant. On grant, latch address/we/wdata into mem_* outputs, set owner and last_grant, set cnt = LATENCY-1, go to BUSY. Writes from IF are impossible; mem_we = 0 for fetches.
- BUSY: mem_en = 1; mem_* outputs held constant. If cnt != 0, decrement. If cnt == 0, capture mem_rdata into the owner's rdata register (load/fetch only), go to DONE.
- DONE: mem_en = 0; owner's ack = 1; increment owner's counter; no grant in this cycle; go to IDLE.
- Stores: d_rdata is unchanged.
- Request inputs are sampled only in IDLE. Changes to addr, wdata, or a dropped req during BUSY are ignored, and the access still completes and acks.
- Reset values: state IDLE, last_grant = I (the first tie goes to D), all outputs 0, including rdata registers and counters.
- Reset asserted in any state: the next edge returns to IDLE with mem_en = 0. The in-flight access is abandoned with no ack and no counter increment.

## Timing
- Request seen in IDLE at cycle t:
  - mem_en high in cycles t+1 .. t+LATENCY
  - ack and rdata valid in cycle t+LATENCY+1
  - IDLE at t+LATENCY+2
- A requester samples ack at the edge ending DONE. A new request must be present in the following IDLE cycle to be considered.
- Peak throughput: one access per LATENCY+2 cycles.
- Under continuous contention, grants alternate D, I, D, I. Neither port waits more than one foreign access.
- mem_* outputs, acks, rdata and counters are registered. Only stall_F and stall_M are combinational.

## Test plan
- Reset: hold reset 2 cycles with both reqs high -> all outputs 0, mem_en never asserted; first grant occurs in the first cycle after reset deasserts.
- Single fetch, LATENCY=2: if_req=1, if_addr=0x00400000 at cycle 0; memory model returns 0x20020004 -> mem_en=1 with mem_addr=0x00400000 in cycles 1–2; if_ack=1 and if_rdata=0x20020004 in cycle 3; stall_F=1 in cycles 0–2; n_fetch=1.
- Simultaneous requests after reset: fetch 0x00400000 and load 0x10010000 at cycle 0 -> D granted first (d_ack cycle 3); I granted in the IDLE cycle 4 (if_ack cycle 7); n_fetch=1, n_data=1.
- Store then load: store 0xDEADBEEF to 0x10010004 -> mem_we=1 for 2 cycles, d_rdata unchanged at d_ack. A subsequent load of 0x10010004 -> d_rdata=0xDEADBEEF.
- Reset mid-access: fetch granted at cycle 0, reset high in cycle 1 -> mem_en=0 from cycle 2, no if_ack, n_fetch=0.
- Sustained contention, LATENCY=1: both reqs held for 12 cycles -> acks alternate d, i, d, i at 3-cycle spacing; 4 acks total; after the burst, input changes made during BUSY cycles do not alter the latched mem_addr.
